// File: rtl/mtm_alu_ctrl.sv
// Transaction controller for the mtm_alu serial link: serializes one {B, A, op, CRC4}
// request onto sin, then deserializes and CRC3-checks the reply arriving on sout.
module mtm_alu_ctrl #(
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    input  logic        req_bad_crc,
    output logic        sin,
    input  logic        sout,
    output logic        resp_valid,
    output logic [31:0] resp_c,
    output logic [3:0]  resp_flags,
    output logic        resp_crc_ok,
    output logic        resp_err,
    output logic [5:0]  resp_err_flags,
    output logic        resp_timeout,
    output logic        busy
);

    localparam int TX_BITS = 99;
    localparam int CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        TX,
        WAIT,
        RX,
        GAP,
        DONE
    } state_t;

    state_t              state;
    logic                idle_q;
    logic [TX_BITS-1:0]  tx_shift;
    logic [6:0]          tx_cnt;
    logic [CNT_W-1:0]    wait_cnt;
    logic [8:0]          rx_sh;
    logic [3:0]          rx_bit;
    logic [2:0]          rx_frame;
    logic [31:0]         c_acc;
    logic                frame_err;

    logic [3:0]          tx_crc;
    logic [TX_BITS-1:0]  tx_word;
    logic                rx_type;
    logic [7:0]          rx_pay;
    logic                crc3_ok;

    // MSB-first LFSR form of the CRC, init 0, x^4+x+1
    function automatic logic [3:0] crc4_calc(input logic [67:0] msg);
        logic [3:0] crc;
        crc = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            crc = {crc[2:0], 1'b0} ^ (((crc[3] ^ msg[i]) == 1'b1) ? 4'b0011 : 4'b0000);
        end
        return crc;
    endfunction

    function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
        logic [2:0] crc;
        crc = 3'b000;
        for (int i = 36; i >= 0; i--) begin
            crc = {crc[1:0], 1'b0} ^ (((crc[2] ^ msg[i]) == 1'b1) ? 3'b011 : 3'b000);
        end
        return crc;
    endfunction

    function automatic logic [10:0] frame(input logic is_cmd, input logic [7:0] payload);
        return {1'b0, is_cmd, payload, 1'b1};
    endfunction

    always_comb begin
        tx_crc  = crc4_calc({req_b, req_a, 1'b1, req_op}) ^ {4{req_bad_crc}};
        tx_word = {frame(1'b0, req_b[31:24]), frame(1'b0, req_b[23:16]),
                   frame(1'b0, req_b[15:8]),  frame(1'b0, req_b[7:0]),
                   frame(1'b0, req_a[31:24]), frame(1'b0, req_a[23:16]),
                   frame(1'b0, req_a[15:8]),  frame(1'b0, req_a[7:0]),
                   frame(1'b1, {1'b0, req_op, tx_crc})};
    end

    // rx_sh holds {type, payload} once the stop bit is on sout
    assign rx_type   = rx_sh[8];
    assign rx_pay    = rx_sh[7:0];
    assign crc3_ok   = (crc3_calc({c_acc, 1'b0, rx_pay[6:3]}) == rx_pay[2:0]);
    assign req_ready = idle_q & rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            idle_q         <= 1'b1;
            busy           <= 1'b0;
            sin            <= 1'b1;
            tx_shift       <= '0;
            tx_cnt         <= '0;
            wait_cnt       <= '0;
            rx_sh          <= '0;
            rx_bit         <= '0;
            rx_frame       <= '0;
            c_acc          <= '0;
            frame_err      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_c         <= '0;
            resp_flags     <= '0;
            resp_crc_ok    <= 1'b0;
            resp_err       <= 1'b0;
            resp_err_flags <= '0;
            resp_timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        sin      <= tx_word[TX_BITS-1];
                        tx_shift <= {tx_word[TX_BITS-2:0], 1'b1};
                        tx_cnt   <= 7'(TX_BITS - 1);
                        idle_q   <= 1'b0;
                        busy     <= 1'b1;
                        state    <= TX;
                    end
                end

                TX: begin
                    if (tx_cnt != 7'd0) begin
                        sin      <= tx_shift[TX_BITS-1];
                        tx_shift <= {tx_shift[TX_BITS-2:0], 1'b1};
                        tx_cnt   <= tx_cnt - 7'd1;
                    end else begin
                        sin      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end

                // WAIT precedes the first reply frame; GAP sits between later frames
                WAIT, GAP: begin
                    if (!sout) begin
                        rx_bit <= '0;
                        state  <= RX;
                        if (state == WAIT) begin
                            rx_frame  <= '0;
                            frame_err <= 1'b0;
                        end
                    end else if (wait_cnt == CNT_LAST) begin
                        resp_valid     <= 1'b1;
                        resp_timeout   <= 1'b1;
                        resp_c         <= '0;
                        resp_flags     <= '0;
                        resp_err       <= 1'b0;
                        resp_err_flags <= '0;
                        resp_crc_ok    <= 1'b0;
                        state          <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RX: begin
                    if (rx_bit != 4'd9) begin
                        rx_sh  <= {rx_sh[7:0], sout};
                        rx_bit <= rx_bit + 4'd1;
                    end else if (rx_frame == 3'd0 && rx_type && rx_pay[7]) begin
                        resp_valid     <= 1'b1;
                        resp_err       <= 1'b1;
                        resp_err_flags <= rx_pay[6:1];
                        resp_c         <= '0;
                        resp_flags     <= '0;
                        resp_timeout   <= 1'b0;
                        resp_crc_ok    <= sout;
                        state          <= DONE;
                    end else if (rx_frame != 3'd4) begin
                        c_acc     <= {c_acc[23:0], rx_pay};
                        rx_frame  <= rx_frame + 3'd1;
                        frame_err <= frame_err | ~sout;
                        wait_cnt  <= '0;
                        state     <= GAP;
                    end else begin
                        resp_valid     <= 1'b1;
                        resp_c         <= c_acc;
                        resp_flags     <= rx_pay[6:3];
                        resp_crc_ok    <= crc3_ok & ~frame_err & sout;
                        resp_err       <= 1'b0;
                        resp_err_flags <= '0;
                        resp_timeout   <= 1'b0;
                        state          <= DONE;
                    end
                end

                DONE: begin
                    resp_valid <= 1'b0;
                    idle_q     <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    idle_q <= 1'b1;
                    busy   <= 1'b0;
                    sin    <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// Self-checking bench for mtm_alu_ctrl: acts as the serial ALU on sin/sout and compares
// responses against a polynomial-division reference model.
module tb_mtm_alu_ctrl;

    localparam int TO = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic        req_bad_crc;
    logic        sin;
    logic        sout;
    logic        resp_valid;
    logic [31:0] resp_c;
    logic [3:0]  resp_flags;
    logic        resp_crc_ok;
    logic        resp_err;
    logic [5:0]  resp_err_flags;
    logic        resp_timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [98:0] tx_cap;

    always #5 clk = ~clk;

    mtm_alu_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_bad_crc(req_bad_crc),
        .sin(sin), .sout(sout),
        .resp_valid(resp_valid), .resp_c(resp_c), .resp_flags(resp_flags),
        .resp_crc_ok(resp_crc_ok), .resp_err(resp_err), .resp_err_flags(resp_err_flags),
        .resp_timeout(resp_timeout), .busy(busy)
    );

    always @(negedge clk) if (resp_valid === 1'b1) pulses++;

    // Remainder of M(x)*x^4 divided by x^4+x+1, by long division
    function automatic logic [3:0] ref_crc4(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [71:0] r;
        r = {b, a, 1'b1, op, 4'b0000};
        for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    function automatic logic [2:0] ref_crc3(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] r;
        r = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
        return r[2:0];
    endfunction

    function automatic logic [98:0] ref_tx(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic bad);
        logic [63:0] data;
        logic [98:0] v;
        logic [3:0]  crc;
        data = {b, a};
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[87:0], 1'b0, 1'b0, data[63-8*k -: 8], 1'b1};
        crc = ref_crc4(a, b, op) ^ {4{bad}};
        v = {v[87:0], 1'b0, 1'b1, 1'b0, op, crc, 1'b1};
        return v;
    endfunction

    // ALU behaviour: {C, carry, overflow, zero, negative}
    function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] c;
        logic cy, ov;
        cy = 1'b0; ov = 1'b0; s = '0;
        case (op)
            3'b000: c = a & b;
            3'b001: c = a | b;
            3'b100: begin
                s = {1'b0, a} + {1'b0, b}; c = s[31:0]; cy = s[32];
                ov = (a[31] == b[31]) && (c[31] != a[31]);
            end
            3'b101: begin
                s = {1'b0, b} - {1'b0, a}; c = s[31:0]; cy = s[32];
                ov = (a[31] != b[31]) && (c[31] != b[31]);
            end
            default: c = a ^ b;
        endcase
        return {c, cy, ov, (c == 32'd0), c[31]};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Handshake a request and capture all 99 transmitted bits; optionally pokes req_valid while busy
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                 input logic bad, input bit poke);
        @(negedge clk);
        checkOutput("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_bad_crc = bad;
        @(negedge clk);
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_op = 3'($urandom); req_bad_crc = 1'b0;
        checkOutput("busy_tx", busy, 1);
        checkOutput("req_ready_busy", req_ready, 0);
        for (int k = 0; k < 99; k++) begin
            if (k > 0) @(negedge clk);
            tx_cap[98-k] = sin;
            if (poke) req_valid = (k >= 10 && k < 30);
        end
        req_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(negedge clk); sout = 1'b1; end
    endtask

    task automatic send_frame(input logic is_cmd, input logic [7:0] payload, input logic stop);
        logic [10:0] bits;
        bits = {1'b0, is_cmd, payload, stop};
        for (int j = 10; j >= 0; j--) begin @(negedge clk); sout = bits[j]; end
    endtask

    task automatic await_resp(input int max_cyc, output int lat);
        lat = 0;
        do begin @(negedge clk); sout = 1'b1; lat++; end
        while (resp_valid !== 1'b1 && lat < max_cyc);
    endtask

    task automatic run_normal(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input int gap_max, input logic [2:0] crc_flip,
                              input int bad_stop, input bit poke);
        logic [35:0] r;
        logic [2:0]  crc3;
        int lat, p0;
        p0 = pulses;
        applyStimulus(a, b, op, 1'b0, poke);
        checkOutput({tag, "_tx"}, tx_cap, ref_tx(a, b, op, 1'b0));
        r = ref_alu(a, b, op);
        crc3 = ref_crc3(r[35:4], r[3:0]) ^ crc_flip;
        for (int fr = 0; fr < 4; fr++) begin
            idle_cycles($urandom_range(gap_max, 0));
            send_frame(1'b0, r[35-8*fr -: 8], fr != bad_stop);
        end
        idle_cycles($urandom_range(gap_max, 0));
        send_frame(1'b1, {1'b0, r[3:0], crc3}, 1'b1);
        await_resp(8, lat);
        checkOutput({tag, "_latency"}, lat, 1);
        checkOutput({tag, "_c"}, resp_c, r[35:4]);
        checkOutput({tag, "_flags"}, resp_flags, r[3:0]);
        checkOutput({tag, "_crc_ok"}, resp_crc_ok, (crc_flip == 3'b000 && bad_stop < 0));
        checkOutput({tag, "_err"}, {resp_err, resp_err_flags, resp_timeout}, 0);
        @(negedge clk);
        checkOutput({tag, "_idle_after"}, {busy, sin}, 2'b01);
        idle_cycles(3);
        checkOutput({tag, "_no_queue"}, {busy, sin}, 2'b01);
        checkOutput({tag, "_pulses"}, pulses, p0 + 1);
    endtask

    task automatic run_timeout(input string tag, input int frames_sent);
        int lat, p0;
        logic [31:0] a, b;
        p0 = pulses;
        a = $urandom; b = $urandom;
        applyStimulus(a, b, 3'b100, 1'b0, 1'b0);
        for (int fr = 0; fr < frames_sent; fr++) send_frame(1'b0, 8'($urandom), 1'b1);
        await_resp(TO + 20, lat);
        checkOutput({tag, "_latency"}, lat, TO + 1);
        checkOutput({tag, "_timeout"}, resp_timeout, 1);
        checkOutput({tag, "_cleared"}, {resp_c, resp_flags, resp_err, resp_err_flags}, 0);
        idle_cycles(2);
        checkOutput({tag, "_pulses"}, pulses, p0 + 1);
    endtask

    initial begin
        int lat, p0;
        logic [35:0] r;
        logic [2:0]  ops [5];
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b100; ops[3] = 3'b101; ops[4] = 3'b110;

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_bad_crc = 1'b0;
        sout = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {sin, req_ready, busy, resp_valid}, 4'b1000);
        checkOutput("reset_fields", {resp_c, resp_flags, resp_crc_ok, resp_err, resp_err_flags, resp_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", req_ready, 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checkOutput("idle", {sin, req_ready, resp_valid}, 3'b110);
        end

        run_normal("basic", 32'd1, 32'd2, 3'b100, 0, 3'b000, -1, 1'b0);
        checkOutput("basic_first_frame", tx_cap[98:88], 11'b0_0_00000000_1);
        checkOutput("basic_cmd_crc", tx_cap[4:1], ref_crc4(32'd1, 32'd2, 3'b100));
        checkOutput("basic_c3", resp_c, 32'd3);

        // Bad CRC4 request: the ALU model answers with an error frame
        p0 = pulses;
        applyStimulus(32'd1, 32'd2, 3'b100, 1'b1, 1'b0);
        checkOutput("badcrc_tx", tx_cap, ref_tx(32'd1, 32'd2, 3'b100, 1'b1));
        if (tx_cap[4:1] != ref_crc4(32'd1, 32'd2, 3'b100)) send_frame(1'b1, 8'hA5, 1'b1);
        else begin
            r = ref_alu(32'd1, 32'd2, 3'b100);
            for (int fr = 0; fr < 4; fr++) send_frame(1'b0, r[35-8*fr -: 8], 1'b1);
            send_frame(1'b1, {1'b0, r[3:0], ref_crc3(r[35:4], r[3:0])}, 1'b1);
        end
        await_resp(8, lat);
        checkOutput("err_latency", lat, 1);
        checkOutput("err_flag", resp_err, 1);
        checkOutput("err_flags", resp_err_flags, 6'b010010);
        checkOutput("err_c_flags", {resp_c, resp_flags, resp_timeout}, 0);
        idle_cycles(2);
        checkOutput("err_pulses", pulses, p0 + 1);

        run_timeout("to_wait", 0);
        run_normal("crc3_bad", 32'h8000_0001, 32'h8000_0002, 3'b100, 2, 3'b001, -1, 1'b0);
        run_timeout("to_gap", 2);
        run_normal("framing", 32'h1234_5678, 32'h9ABC_DEF0, 3'b001, 2, 3'b000, 1, 1'b0);

        // Reset asserted while TX bit 40 is on the line aborts without a response
        p0 = pulses;
        @(negedge clk);
        req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h0BAD_F00D; req_op = 3'b101;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("abort_bit40", sin, ref_tx(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, 1'b0) >> 58 & 99'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort_reset", {sin, busy, req_ready, resp_valid}, 4'b1000);
        checkOutput("abort_fields", {resp_c, resp_flags, resp_crc_ok, resp_timeout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_ready", {sin, req_ready}, 2'b11);
        idle_cycles(120);
        checkOutput("abort_no_resp", pulses, p0);

        run_normal("post_abort", 32'hDEAD_BEEF, 32'h0BAD_F00D, 3'b101, 1, 3'b000, -1, 1'b0);

        for (int t = 0; t < 8; t++) begin
            run_normal("rand", $urandom, $urandom, ops[$urandom_range(4, 0)], 4, 3'b000, -1, t == 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mtm_alu_ctrl.md
# mtm_alu_ctrl

Transaction controller that sequences one serial ALU operation at a time on the `mtm_alu` serial link. It accepts a parallel request (A, B, op), computes the 4-bit command CRC, and serializes the 9-frame request onto `sin`. It then deserializes the ALU reply from `sout`, checks its CRC and presents a parallel response. It sits between parallel requesters (testbench drivers, future arbiter) and the DUT's serial pins.

## Interface
Parameters:
- `TIMEOUT_CYC`, 2000: cycles allowed from the end of the last transmitted stop bit to the first reply start bit.

Ports:
- `clk`  in  1  single clock; one serial bit per cycle.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; transfer when `req_valid & req_ready`.
- `req_a`, `req_b`  in  32 each  operands.
- `req_op`  in  3  opcode, passed through uninterpreted.
- `req_bad_crc`  in  1  when set, the transmitted CRC4 is bit-inverted (error injection).
- `sin`  out  1  serial line to the ALU; idles high.
- `sout`  in  1  serial line from the ALU; idles high.
- `resp_valid`  out  1  one-cycle pulse; response fields valid in that cycle and held until the next pulse.
- `resp_c`  out  32  result.
- `resp_flags`  out  4  {carry, overflow, zero, negative}.
- `resp_crc_ok`  out  1  received CRC3 matches the computed value.
- `resp_err`  out  1  ALU returned an error frame.
- `resp_err_flags`  out  6  error frame payload bits [6:1].
- `resp_timeout`  out  1  no reply within `TIMEOUT_CYC`.
- `busy`  out  1  not IDLE.

## Operation
- Frame format, 11 bits, sent first to last: start 0, type bit (0 = data, 1 = cmd), 8 payload bits MSB first, stop 1.
- Request sequence: 8 data frames (B[31:24], B[23:16], B[15:8], B[7:0], then A in the same byte order), then 1 cmd frame with payload {1'b0, op[2:0], crc4[3:0]}.
- CRC4: polynomial x^4+x+1, init 0, computed MSB first over the 68-bit message {B, A, 1'b1, op}.
- Reply sequences:
  - Normal: 4 data frames carrying C, MSB byte first, then a cmd frame with payload {1'b0, flags[3:0], crc3[2:0]}.
  - Error: a single cmd frame with payload {1'b1, err_flags[5:0], parity}.
- CRC3: polynomial x^3+x+1, init 0, computed over the 37-bit message {C, 1'b0, flags}.
- States:
  - IDLE: `req_ready` = 1. On handshake, latch the inputs, compute CRC4, go to TX.
  - TX: shift out 99 bits, then go to WAIT.
  - WAIT: count cycles. `sout` = 0 goes to RX. When the count reaches `TIMEOUT_CYC`, go to DONE with `resp_timeout` = 1.
  - RX: sample 10 more bits per frame (`sout` sampled every cycle).
    - A type-1 first frame with payload[7] = 1 is an error response: capture `err_flags`, go to DONE.
    - Otherwise collect 5 frames, then go to DONE.
    - Between frames, wait for the next start bit. The inter-frame gap is unbounded but counts against the same timeout counter, which restarts at each stop bit.
  - DONE: assert `resp_valid` for 1 cycle, return to IDLE.
- A stop bit sampled as 0 is a framing error: set `resp_crc_ok` = 0 and finish the frame count normally.
- Every response clears the stale fields: a timeout response sets C, flags and `err_flags` to 0; an error response sets C and flags to 0.

## Timing
- Reset values: `sin` = 1, `req_ready` = 0 during reset and 1 in the first cycle after, `busy` = 0, `resp_valid` = 0, all response fields 0, state IDLE.
- Reset while `rst_n` is low in any state aborts the transaction; the next cycle is IDLE with `sin` = 1. There is no partial response.
- Request timing:
  - A handshake in cycle n puts the first start bit on `sin` at cycle n+1.
  - The last stop bit is at n+99.
  - WAIT begins at n+100.
- `sin` is registered (a flop output); `sout` is sampled directly with no synchronizer, since the ALU shares `clk`.
- Response timing: `resp_valid` rises the cycle after the final stop bit is sampled, or the cycle after the timeout count is reached.
- `req_valid` asserted while busy is ignored and not queued.

## Test plan
- Reset, then idle: `sin` = 1, `req_ready` = 1, `resp_valid` = 0 for 50 cycles.
- Request A=1, B=2, op=3'b100, ALU model replies normally:
  - The first frame on `sin` is 0,0,0x00,1.
  - The cmd frame's CRC4 matches the model.
  - `resp_c` = 3, `resp_flags` = 4'b0000, `resp_crc_ok` = 1.
- Same request with `req_bad_crc` = 1: the model returns an error frame with payload 0xA5 -> `resp_err` = 1, `resp_err_flags` = 6'b010010, `resp_c` = 0.
- No reply on `sout` -> `resp_valid` with `resp_timeout` = 1 exactly `TIMEOUT_CYC` + 1 cycles after the last stop bit.
- Reply with a corrupted CRC3 bit -> `resp_crc_ok` = 0, and `resp_c` is still captured.
- `rst_n` pulsed low at TX bit 40 -> `sin` = 1 the next cycle and no `resp_valid`; the next request completes correctly.
